pixel_stream_loader: RTL and testbench

PIXEL_STREAM_LOADER -- requirements
Module: pixel_stream_loader

---
 rtl/pixel_stream_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_pixel_stream_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_loader.sv
// -----------------------------------------------------------------------------
// pixel_stream_loader
//
// Purpose:
//   Buffers a stream of source pixels in a small FIFO and replays them to a
//   downstream mainController as single-cycle write strobes. One frame is
//   N*N writes. After each write the loader stays quiet for GAP cycles, and
//   after the last write of a frame it emits a one-cycle frame_done pulse.
//
// Handshake (source side):
//   A pixel is transferred on every rising edge where src_valid=1 and
//   src_ready=1. src_ready is a register that is 1 exactly when the FIFO is
//   not full. It is independent of the FSM, so the FIFO keeps filling while
//   the loader is idle. Pixels that arrive after the last write of a frame
//   stay in the FIFO and start the next frame.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle frame request (honoured only in IDLE)
//   src_valid    in   source has a pixel
//   src_data     in   source pixel [pixelWidth]
//   src_ready    out  loader accepts a pixel this cycle (FIFO not full)
//   we           out  one-cycle write strobe to mainController
//   data_in      out  pixel for mainController, holds its last written value
//   pix_cnt      out  pixels written in the current frame [bitSize+1]
//   busy         out  frame in progress (WRITE or GAP_WAIT)
//   frame_done   out  one-cycle pulse the cycle after the final write
//   fsm_state_o  out  debug view of the FSM state register
//   stall_cnt    out  (PIXEL_LOADER_STALL_COUNT_EN only) cycles starved of data
//
// Configuration macro:
//   PIXEL_LOADER_STALL_COUNT_EN - adds the saturating 16-bit stall_cnt
//   output. It counts cycles spent in WRITE with no strobe and an empty
//   FIFO. The counter clears on reset and on an accepted start.
// -----------------------------------------------------------------------------
module pixel_stream_loader #(
    parameter int N          = 8,
    parameter int pixelWidth = 8,
    parameter int bitSize    = $clog2(N * N),
    parameter int DEPTH      = 4,
    parameter int GAP        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  src_valid,
    input  logic [pixelWidth-1:0] src_data,
    output logic                  src_ready,
    output logic                  we,
    output logic [pixelWidth-1:0] data_in,
    output logic [bitSize:0]      pix_cnt,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            fsm_state_o
`ifdef PIXEL_LOADER_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [bitSize:0] FRAME_PIX  = (bitSize + 1)'(N * N);

    // GAP_WAIT counts down from GAP-1 to 0, giving exactly GAP quiet cycles.
    localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);
    localparam bit         GAP_ZERO = (GAP == 0);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WRITE    = 2'd1;
    localparam logic [1:0] S_GAP_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [pixelWidth-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  src_ready_q, src_ready_d;

    // -------------------------------------------------------------------------
    // FSM and output registers
    // -------------------------------------------------------------------------
    logic [1:0]            state_q,      state_d;
    logic [2:0]            gap_cnt_q,    gap_cnt_d;
    logic                  we_q,         we_d;
    logic [pixelWidth-1:0] data_q,       data_d;
    logic [bitSize:0]      pix_cnt_q,    pix_cnt_d;
    logic                  frame_done_q, frame_done_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic last_pix;
    logic start_ok;

    // src_ready_q always mirrors "not full", so a push can never hit a full
    // FIFO and no push-while-full bypass is needed.
    assign push       = src_valid & src_ready_q;
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == S_WRITE) & ~fifo_empty;
    assign last_pix   = ((pix_cnt_q + 1'b1) == FRAME_PIX);
    assign start_ok   = (state_q == S_IDLE) & start;

    // -------------------------------------------------------------------------
    // FIFO next-state
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        src_ready_d = (count_d != FULL_CNT);
    end

    // -------------------------------------------------------------------------
    // FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        we_d         = 1'b0;
        data_d       = data_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // pix_cnt keeps showing the finished frame until a new start.
                if (start) begin
                    state_d   = S_WRITE;
                    pix_cnt_d = '0;
                end
            end

            S_WRITE: begin
                if (pop) begin
                    we_d      = 1'b1;
                    data_d    = mem_q[rd_ptr_q];
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else if (GAP_ZERO) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d   = S_GAP_WAIT;
                        gap_cnt_d = GAP_LAST;
                    end
                end
            end

            S_GAP_WAIT: begin
                if (gap_cnt_q == 3'd0) begin
                    state_d = S_WRITE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                // The final strobe is visible while in DONE; frame_done
                // follows one cycle later, already back in IDLE.
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            src_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
            gap_cnt_q    <= 3'd0;
            we_q         <= 1'b0;
            data_q       <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            src_ready_q  <= src_ready_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            we_q         <= we_d;
            data_q       <= data_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage has no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= src_data;
        end
    end

    // -------------------------------------------------------------------------
    // Optional stall counter
    // -------------------------------------------------------------------------
`ifdef PIXEL_LOADER_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = 16'd0;
        end else if ((state_q == S_WRITE) && !we_q && fifo_empty &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // start_ok only feeds the stall counter.
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign src_ready   = src_ready_q;
    assign we          = we_q;
    assign data_in     = data_q;
    assign pix_cnt     = pix_cnt_q;
    assign busy        = (state_q == S_WRITE) || (state_q == S_GAP_WAIT);
    assign frame_done  = frame_done_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pixel_stream_loader.sv
// -----------------------------------------------------------------------------
// Bench for pixel_stream_loader.
// "dut" (GAP=1) is compared every cycle against a queue-based model. The
// model tracks a frame as "active", a cooldown before the next write
// is allowed, and a pending frame_done. "dut0" (GAP=0) gets a directed
// back-to-back streaming run.
// -----------------------------------------------------------------------------
module tb_pixel_stream_loader;
  localparam int N      = 8;
  localparam int PW     = 8;
  localparam int DEPTH  = 4;
  localparam int TB_GAP = 1;
  localparam int NN     = N * N;
  localparam int BS     = $clog2(NN);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [PW-1:0] src_data = '0;
  logic          src_ready, we, busy, frame_done;
  logic [PW-1:0] data_in;
  logic [BS:0]   pix_cnt;
  logic [1:0]    fsm_state;

  logic          g0_start = 1'b0;
  logic          g0_valid = 1'b0;
  logic [PW-1:0] g0_data = '0;
  logic          g0_src_ready, g0_we, g0_busy, g0_fd;
  logic [PW-1:0] g0_data_in;
  logic [BS:0]   g0_pix_cnt;
  logic [1:0]    g0_fsm_state;

`ifdef PIXEL_LOADER_STALL_COUNT_EN
  logic [15:0] stall_cnt, g0_stall_cnt;
`endif

  pixel_stream_loader #(.N(N), .pixelWidth(PW), .DEPTH(DEPTH), .GAP(TB_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .we(we), .data_in(data_in),
    .pix_cnt(pix_cnt), .busy(busy), .frame_done(frame_done),
    .fsm_state_o(fsm_state)
`ifdef PIXEL_LOADER_STALL_COUNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pixel_stream_loader #(.N(N), .pixelWidth(PW), .DEPTH(DEPTH), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(g0_start), .src_valid(g0_valid),
    .src_data(g0_data), .src_ready(g0_src_ready), .we(g0_we),
    .data_in(g0_data_in), .pix_cnt(g0_pix_cnt), .busy(g0_busy),
    .frame_done(g0_fd), .fsm_state_o(g0_fsm_state)
`ifdef PIXEL_LOADER_STALL_COUNT_EN
    , .stall_cnt(g0_stall_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Behavioural model of dut (GAP = TB_GAP)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] exp_q[$];
  bit            m_active = 1'b0;
  bit            m_fin    = 1'b0;
  bit            m_we     = 1'b0;
  bit            m_fd     = 1'b0;
  bit            m_ready  = 1'b1;
  logic [PW-1:0] m_data   = '0;
  int            m_cnt    = 0;
  int            m_cool   = 0;
  logic [15:0]   m_stall  = '0;
  bit            acc_flag = 1'b0;

  always @(posedge clk) begin
    bit pop;
    bit was_active;
    bit was_fin;
    acc_flag = rst_n && src_valid && m_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_active = 1'b0; m_fin = 1'b0; m_we = 1'b0; m_fd = 1'b0;
      m_ready = 1'b1; m_data = '0; m_cnt = 0; m_cool = 0; m_stall = '0;
    end else begin
      was_active = m_active;
      was_fin    = m_fin;
      pop = m_active && (m_cool == 0) && (exp_q.size() > 0);
      // Starved: allowed to write, no strobe showing, nothing buffered.
      if (m_active && (m_cool == 0) && !m_we && (exp_q.size() == 0) && (m_stall != 16'hFFFF))
        m_stall++;
      m_we  = pop;
      m_fd  = was_fin;
      m_fin = 1'b0;
      if (pop) begin
        m_data = exp_q.pop_front();
        m_cnt++;
        if (m_cnt == NN) begin
          m_active = 1'b0;
          m_fin    = 1'b1;
        end else begin
          m_cool = TB_GAP;
        end
      end else if (m_active && m_cool > 0) begin
        m_cool--;
      end
      if (start && !was_active && !was_fin) begin
        m_active = 1'b1; m_cnt = 0; m_cool = 0; m_stall = '0;
      end
      if (acc_flag) exp_q.push_back(src_data);
      m_ready = (exp_q.size() < DEPTH);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("we", we, m_we);
      check("data_in", data_in, m_data);
      check("pix_cnt", pix_cnt, m_cnt);
      check("busy", busy, m_active);
      check("frame_done", frame_done, m_fd);
      check("src_ready", src_ready, m_ready);
`ifdef PIXEL_LOADER_STALL_COUNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Write logs used by the directed literal checks
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wlog[$];
  int            wcyc[$];
  int            fd_cnt = 0;
  int            fd_cyc = 0;
  logic [PW-1:0] g0_wlog[$];
  int            g0_wcyc[$];
  int            g0_fd_cnt = 0;
  int            g0_fd_cyc = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin wlog.push_back(data_in); wcyc.push_back(cyc); end
    if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    if (g0_we === 1'b1) begin g0_wlog.push_back(g0_data_in); g0_wcyc.push_back(cyc); end
    if (g0_fd === 1'b1) begin g0_fd_cnt++; g0_fd_cyc = cyc; end
  end

  // ---------------------------------------------------------------------------
  // Source drivers (valid held until accepted)
  // ---------------------------------------------------------------------------
  int            src_left = 0;
  bit            src_rand = 1'b0;
  bit            src_seq  = 1'b1;
  logic [PW-1:0] seq_val  = '0;

  always @(negedge clk) begin
    if (acc_flag) src_valid = 1'b0;
    if (!src_valid && src_left > 0) begin
      if (!src_rand || $urandom_range(0, 2) != 0) begin
        src_valid = 1'b1;
        if (src_seq) begin
          src_data = seq_val;
          seq_val  = seq_val + 1'b1;
        end else begin
          src_data = PW'($urandom);
        end
        src_left--;
      end
    end
  end

  bit g0_on  = 1'b0;
  bit g0_acc = 1'b0;
  always @(posedge clk) g0_acc = g0_valid && g0_src_ready;
  always @(negedge clk) begin
    if (g0_on) begin
      if (g0_valid && g0_acc) g0_data = g0_data + 1'b1;
      g0_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clear_logs();
    @(posedge clk);
    #1;
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic wait_frame_done(input int limit);
    int base;
    int n;
    base = fd_cnt;
    n = 0;
    while (fd_cnt == base && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_seen", (fd_cnt != base), 1);
  endtask

  task automatic wait_writes(input int cnt, input int limit);
    int n;
    n = 0;
    while (wlog.size() < cnt && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("writes_reached", (wlog.size() >= cnt), 1);
  endtask

  // Reset both DUTs and silence the main source while reset is held.
  task automatic reset_and_flush();
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    src_left  = 0;
    src_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state.
    rst_n = 1'b0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_we", we, 0);
    check("rst_pix_cnt", pix_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_src_ready", src_ready, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_data_in", data_in, 0);
    rst_n = 1'b1;

    // Full frame, pixels 0..63, source always valid, FIFO pre-filled.
    @(posedge clk);
    #1;
    seq_val = '0; src_seq = 1'b1; src_rand = 1'b0; src_left = 100000;
    repeat (8) @(negedge clk);
    check("prefill_full", src_ready, 0);
    clear_logs();
    pulse_start();
    wait_frame_done(400);
    check("f1_writes", wlog.size(), 64);
    for (int i = 0; i < wlog.size() && i < 64; i++) begin
      check("f1_data", wlog[i], i);
      if (i > 0) check("f1_spacing", wcyc[i] - wcyc[i-1], 2);
    end
    if (wcyc.size() > 0) check("f1_done_after_last", fd_cyc - wcyc[wcyc.size()-1], 1);
    @(negedge clk);
    check("f1_pix_cnt_hold", pix_cnt, 64);
    check("f1_idle_busy", busy, 0);

    // Pixels that arrived after the last pop open the next frame.
    clear_logs();
    pulse_start();
    wait_frame_done(400);
    if (wlog.size() > 0) check("f2_first_retained", wlog[0], 64);
    check("f2_writes", wlog.size(), 64);

    // Five pixels while idle: four buffered, fifth held; then start, and a
    // start pulse mid-frame that must be ignored.
    reset_and_flush();
    @(posedge clk);
    #1;
    seq_val = 8'd1; src_seq = 1'b1; src_rand = 1'b0; src_left = 5;
    repeat (10) @(negedge clk);
    check("idle5_ready", src_ready, 0);
    check("idle5_src_pending", src_valid, 1);
    check("idle5_pix_cnt", pix_cnt, 0);
    clear_logs();
    src_left = src_left + 59;
    pulse_start();
    wait_writes(10, 300);
    pulse_start();
    wait_frame_done(400);
    check("f3_writes", wlog.size(), 64);
    for (int i = 0; i < wlog.size() && i < 64; i++) check("f3_data", wlog[i], i + 1);
    @(negedge clk);
    check("f3_pix_cnt", pix_cnt, 64);

    // Reset mid-frame after 20 writes, then a full frame afterwards.
    @(posedge clk);
    #1;
    src_seq = 1'b0; src_rand = 1'b1; src_left = 100000;
    clear_logs();
    pulse_start();
    wait_writes(20, 300);
    begin
      int fd_base;
      fd_base = fd_cnt;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      check("midrst_we", we, 0);
      check("midrst_pix_cnt", pix_cnt, 0);
      check("midrst_busy", busy, 0);
      check("midrst_src_ready", src_ready, 1);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_no_done", fd_cnt - fd_base, 0);
    end
    clear_logs();
    pulse_start();
    wait_frame_done(1000);
    check("f4_writes", wlog.size(), 64);

    // Randomized frames with random idle gaps before start.
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      clear_logs();
      pulse_start();
      wait_frame_done(1000);
      check("rand_writes", wlog.size(), 64);
    end

    // GAP=0 instance: continuous streaming, writes on consecutive cycles.
    @(posedge clk);
    #1 src_left = 0;
    g0_on = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk) g0_start = 1'b1;
    @(negedge clk) g0_start = 1'b0;
    begin
      int n;
      n = 0;
      while (g0_fd_cnt == 0 && n < 300) begin
        @(posedge clk);
        n++;
      end
    end
    check("g0_done_seen", (g0_fd_cnt != 0), 1);
    check("g0_writes", g0_wlog.size(), 64);
    for (int i = 0; i < g0_wlog.size() && i < 64; i++) check("g0_data", g0_wlog[i], i);
    if (g0_wcyc.size() == 64) begin
      check("g0_back_to_back", g0_wcyc[63] - g0_wcyc[0], 63);
      check("g0_done_after_last", g0_fd_cyc - g0_wcyc[63], 1);
    end
    @(negedge clk);
    check("g0_pix_cnt", g0_pix_cnt, 64);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
